// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, line levels and parity helper.
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    // Line levels of the frame bits; shared with the receiver side.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic MARK      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } uart_state_e;

    // Even parity bit: makes the data bits plus parity contain an even number of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic ck,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == TERM);

    // Next count: restart on clear or terminal count, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge ck) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a registered-output FIFO: pops a byte, sends 8N1 or 8E1.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_ren,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic              parity_q, parity_d;
    logic              baud_clr;
    logic              baud_tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .ck  (ck),
        .rst (rst),
        .clr (baud_clr),
        .tick(baud_tick)
    );

    // State register.
    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every serial state leaves only on a baud tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (tx_en && !fifo_empty) state_d = ST_READ;
            ST_READ:   state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (baud_tick) state_d = ST_DATA;
            ST_DATA: begin
                if (baud_tick && (bitcnt_q == LAST_BIT)) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (baud_tick) state_d = ST_STOP;
            ST_STOP:   if (baud_tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: byte capture in LOAD, LSB-first shift in DATA.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        parity_d = parity_q;
        case (state_q)
            ST_LOAD: begin
                shreg_d  = fifo_dout;
                parity_d = even_parity(fifo_dout);
            end
            ST_START: begin
                if (baud_tick) bitcnt_d = '0;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
                    if (bitcnt_q != LAST_BIT) bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge ck) begin
        if (!rst) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            parity_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            parity_q <= parity_d;
        end
    end

    // Moore output decode; the baud counter is held clear until the start bit begins.
    always_comb begin
        txd        = MARK;
        fifo_ren   = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != ST_IDLE);
        baud_clr   = 1'b0;
        case (state_q)
            ST_IDLE:   baud_clr = 1'b1;
            ST_READ: begin
                fifo_ren = 1'b1;
                baud_clr = 1'b1;
            end
            ST_LOAD:   baud_clr = 1'b1;
            ST_START:  txd = START_BIT;
            ST_DATA:   txd = shreg_q[0];
            ST_PARITY: txd = parity_q;
            ST_STOP: begin
                txd        = STOP_BIT;
                frame_done = baud_tick;
            end
            default: ;
        endcase
    end

endmodule
